// File: rtl/ringbuffer_uart_drain_pkg.sv
// Shared types and constants for the ringbuffer UART drain.
package ringbuffer_uart_drain_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    TRAIL   = 3'd4
  } state_t;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam logic [7:0]  DEFAULT_TRAILER = 8'h0A;

  // Number of whole bytes needed to carry a dw-bit entry.
  function automatic int unsigned bytes_for(input int unsigned dw);
    return (dw + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/ringbuffer_uart_drain_uart_tx.sv
// 8N1 byte transmitter: LSB first, each bit held CLKS_PER_BIT cycles.
module uart_tx_byte
  import ringbuffer_uart_drain_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       IDX_LAST = 4'(UART_FRAME_BITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shreg;

  // Bit timing and serialisation; done is raised for the final stop-bit cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      done <= busy && (bit_idx == IDX_LAST) && (cnt == CNT_PRE);
      if (!busy) begin
        if (start) begin
          tx      <= 1'b0;
          busy    <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
          shreg   <= {1'b1, data};
        end
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (bit_idx == IDX_LAST) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ringbuffer_uart_drain.sv
// Pops ringbuffer entries and streams them MSB byte first over UART, then a trailer.
module ringbuffer_uart_drain
  import ringbuffer_uart_drain_pkg::*;
#(
  parameter int unsigned DW           = 48,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  TRAILER      = DEFAULT_TRAILER
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] read_data,
  input  logic          empty,
  input  logic          overflow,
  output logic          read_clock_enable,
  output logic          uart_tx,
  output logic          busy,
  output logic          overflow_seen,
  output logic [15:0]   frames_sent
);

  localparam int unsigned BYTES = bytes_for(DW);
  localparam int unsigned PW    = BYTES * 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(BYTES - 1);

  state_t           state;
  state_t           state_next;
  logic [PW-1:0]    shreg;
  logic [IDX_W-1:0] byte_idx;
  logic [PW-1:0]    padded_c;
  logic             start_c;
  logic [7:0]       tx_data_c;
  logic             tx_busy;
  logic             tx_done;

  assign padded_c = PW'(read_data);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and byte-start control; a byte starts whenever the transmitter is free.
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    tx_data_c  = shreg[PW-1 -: 8];
    unique case (state)
      IDLE: begin
        if (!empty) state_next = POP;
      end
      POP: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        start_c    = 1'b1;
        tx_data_c  = padded_c[PW-1 -: 8];
        state_next = SEND;
      end
      SEND: begin
        if (!tx_busy) start_c = 1'b1;
        if (tx_done && (byte_idx == '0)) state_next = TRAIL;
      end
      TRAIL: begin
        tx_data_c = TRAILER;
        if (!tx_busy) start_c = 1'b1;
        if (tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Entry shift register, byte counter, registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg             <= '0;
      byte_idx          <= '0;
      read_clock_enable <= 1'b0;
      busy              <= 1'b0;
      overflow_seen     <= 1'b0;
      frames_sent       <= '0;
    end else begin
      read_clock_enable <= (state_next == POP);
      busy              <= (state_next != IDLE);
      if (overflow) overflow_seen <= 1'b1;
      if (state == CAPTURE) begin
        shreg    <= padded_c;
        byte_idx <= IDX_TOP;
      end else if ((state == SEND) && tx_done && (byte_idx != '0)) begin
        shreg    <= shreg << 8;
        byte_idx <= byte_idx - IDX_W'(1);
      end
      if ((state == TRAIL) && tx_done) frames_sent <= frames_sent + 16'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock(clock),
    .reset(reset),
    .start(start_c),
    .data (tx_data_c),
    .tx   (uart_tx),
    .busy (tx_busy),
    .done (tx_done)
  );

endmodule
